// File: rtl/pad_attr_pkg.sv
// Shared types for the pad attribute sequencer.
//   pad_type_e : 2-bit pad flavour (value 3 is reserved)
//   pad_attr_t : {od_en, pull_sel, pull_en, invert}
//   cap_mask() : attribute bits a given pad flavour can actually implement
package pad_attr_pkg;

  localparam int unsigned AttrW = 4;

  typedef enum logic [1:0] {
    InputStd = 2'd0,
    BidirStd = 2'd1,
    AnalogIn = 2'd2
  } pad_type_e;

  typedef struct packed {
    logic od_en;
    logic pull_sel;
    logic pull_en;
    logic invert;
  } pad_attr_t;

  // Writable attribute bits per pad flavour; reserved encodings expose nothing.
  function automatic pad_attr_t cap_mask(pad_type_e t);
    pad_attr_t m;
    case (t)
      InputStd: m = pad_attr_t'(4'b0111);
      BidirStd: m = pad_attr_t'(4'b1111);
      default:  m = pad_attr_t'(4'b0000);
    endcase
    return m;
  endfunction

endpackage

// File: rtl/pad_attr_reg.sv
// Single pad attribute register with sticky lock.
//   clk_i, rst_ni : clock, async active-low reset
//   we_i          : commit data_i this cycle (ignored once locked)
//   lock_set_i    : lock the pad together with the commit
//   data_i        : attribute to commit
//   attr_o        : committed attribute, always within the capability mask
//   lock_o        : sticky lock status
module pad_attr_reg
  import pad_attr_pkg::*;
#(
  parameter pad_type_e        PadType   = BidirStd,
  parameter logic [AttrW-1:0] ResetAttr = '0
) (
  input  logic      clk_i,
  input  logic      rst_ni,
  input  logic      we_i,
  input  logic      lock_set_i,
  input  pad_attr_t data_i,
  output pad_attr_t attr_o,
  output logic      lock_o
);

  localparam pad_attr_t CapMask  = cap_mask(PadType);
  localparam pad_attr_t ResetVal = pad_attr_t'(ResetAttr & CapMask);

  pad_attr_t attr_q, attr_d;
  logic      lock_q, lock_d;

  // Next state: a locked pad never changes; the mask is reapplied locally.
  always_comb begin
    attr_d = attr_q;
    lock_d = lock_q;
    if (we_i && !lock_q) begin
      attr_d = pad_attr_t'(data_i & CapMask);
      lock_d = lock_set_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      attr_q <= ResetVal;
      lock_q <= 1'b0;
    end else begin
      attr_q <= attr_d;
      lock_q <= lock_d;
    end
  end

  assign attr_o = attr_q;
  assign lock_o = lock_q;

endmodule

// File: rtl/pad_attr_sequencer.sv
// Multi-pad attribute sequencer: accepts attribute writes over valid/ready,
// masks them by pad capability, commits, then holds off for a settle interval.
//   clk_i, rst_ni            : clock, async active-low reset
//   req_valid_i/req_ready_o  : write request handshake
//   req_pad_i/attr_i/lock_i  : target pad, requested attribute, lock-after-write
//   rsp_valid_o              : one-cycle response pulse
//   rsp_attr_o/err_o/masked_o: committed value, rejection, bits cleared by mask
//   attr_o                   : committed attributes, pad i at [i*AttrW +: AttrW]
//   lock_o                   : per-pad sticky locks
//   busy_o                   : settle interval in progress
module pad_attr_sequencer
  import pad_attr_pkg::*;
#(
  parameter int unsigned                NumPads      = 4,
  parameter int unsigned                SettleCycles = 3,
  parameter logic [NumPads-1:0][1:0]    PadTypes     = {NumPads{2'(BidirStd)}},
  parameter logic [AttrW-1:0]           ResetAttr    = '0,
  localparam int unsigned               PadIdxW      = (NumPads > 1) ? $clog2(NumPads) : 1
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       req_valid_i,
  output logic                       req_ready_o,
  input  logic [PadIdxW-1:0]         req_pad_i,
  input  logic [AttrW-1:0]           req_attr_i,
  input  logic                       req_lock_i,
  output logic                       rsp_valid_o,
  output logic [AttrW-1:0]           rsp_attr_o,
  output logic                       rsp_err_o,
  output logic                       rsp_masked_o,
  output logic [NumPads*AttrW-1:0]   attr_o,
  output logic [NumPads-1:0]         lock_o,
  output logic                       busy_o
);

  localparam int unsigned CntW = 4;

  typedef enum logic {
    StIdle   = 1'b0,
    StSettle = 1'b1
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            ready_q, ready_d;
  logic            busy_q, busy_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            rsp_err_q, rsp_err_d;
  logic            rsp_masked_q, rsp_masked_d;
  pad_attr_t       rsp_attr_q, rsp_attr_d;

  logic [NumPads-1:0] lock_w;
  logic [NumPads-1:0] we;
  pad_attr_t          sel_mask;
  pad_attr_t          wdata;
  logic               sel_lock;
  logic               pad_ok;
  logic               accept;
  logic               commit;

  // Capability mask and lock of the addressed pad.
  always_comb begin
    sel_mask = '0;
    sel_lock = 1'b0;
    for (int unsigned i = 0; i < NumPads; i++) begin
      if (req_pad_i == PadIdxW'(i)) begin
        sel_mask = cap_mask(pad_type_e'(PadTypes[i]));
        sel_lock = lock_w[i];
      end
    end
  end

  assign pad_ok = 32'(req_pad_i) < NumPads;
  assign accept = req_valid_i && ready_q;
  assign commit = accept && pad_ok && !sel_lock;
  assign wdata  = pad_attr_t'(req_attr_i & sel_mask);

  // One-hot write enable toward the addressed pad register.
  always_comb begin
    we = '0;
    for (int unsigned i = 0; i < NumPads; i++) begin
      we[i] = commit && (req_pad_i == PadIdxW'(i));
    end
  end

  // Sequencer next-state and response generation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    rsp_valid_d  = 1'b0;
    rsp_err_d    = 1'b0;
    rsp_masked_d = 1'b0;
    rsp_attr_d   = '0;
    case (state_q)
      StIdle: begin
        if (accept) begin
          rsp_valid_d = 1'b1;
          if (commit) begin
            rsp_attr_d   = wdata;
            rsp_masked_d = |(req_attr_i & ~sel_mask);
            if (SettleCycles != 0) begin
              state_d = StSettle;
              cnt_d   = CntW'(SettleCycles);
            end
          end else begin
            rsp_err_d = 1'b1;
          end
        end
      end
      StSettle: begin
        // Counter holds the remaining low-ready cycles including this one.
        if (cnt_q <= 4'd1) begin
          state_d = StIdle;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
      end
    endcase
    ready_d = (state_d == StIdle);
    busy_d  = (state_d == StSettle);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= StIdle;
      cnt_q        <= '0;
      ready_q      <= 1'b1;
      busy_q       <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_err_q    <= 1'b0;
      rsp_masked_q <= 1'b0;
      rsp_attr_q   <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ready_q      <= ready_d;
      busy_q       <= busy_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_err_q    <= rsp_err_d;
      rsp_masked_q <= rsp_masked_d;
      rsp_attr_q   <= rsp_attr_d;
    end
  end

  for (genvar g = 0; g < NumPads; g++) begin : g_pad
    pad_attr_t attr_g;
    pad_attr_reg #(
      .PadType   (pad_type_e'(PadTypes[g])),
      .ResetAttr (ResetAttr)
    ) u_reg (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .we_i       (we[g]),
      .lock_set_i (req_lock_i),
      .data_i     (wdata),
      .attr_o     (attr_g),
      .lock_o     (lock_w[g])
    );
    assign attr_o[g*AttrW +: AttrW] = attr_g;
  end

  assign req_ready_o  = ready_q;
  assign busy_o       = busy_q;
  assign rsp_valid_o  = rsp_valid_q;
  assign rsp_err_o    = rsp_err_q;
  assign rsp_masked_o = rsp_masked_q;
  assign rsp_attr_o   = rsp_attr_q;
  assign lock_o       = lock_w;

  a_settle_range: assert property (@(posedge clk_i) SettleCycles <= 15);
  a_num_pads:     assert property (@(posedge clk_i) NumPads >= 1);
  a_req_stable:   assert property (@(posedge clk_i) disable iff (!rst_ni)
                    (req_valid_i && !req_ready_o) |=>
                    (req_valid_i && $stable(req_pad_i) && $stable(req_attr_i) && $stable(req_lock_i)));

endmodule

// File: tb/tb_pad_attr_sequencer.sv
// Scoreboard bench for pad_attr_sequencer: instance 0 (4 pads, settle 3),
// instance 1 (3 pads, settle 0, includes a reserved pad type).
module tb_pad_attr_sequencer;

  localparam int ND = 2;

  typedef struct packed {
    logic        err;
    logic        masked;
    logic [3:0]  attr;
    logic [15:0] av;
    logic [3:0]  lv;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n     [ND];
  logic       req_valid [ND];
  logic [1:0] req_pad   [ND];
  logic [3:0] req_attr  [ND];
  logic       req_lock  [ND];

  logic        req_ready  [ND];
  logic        rsp_valid  [ND];
  logic [3:0]  rsp_attr   [ND];
  logic        rsp_err    [ND];
  logic        rsp_masked [ND];
  logic [15:0] attr_w     [ND];
  logic [3:0]  lock_w     [ND];
  logic        busy       [ND];

  logic        rdy0, rv0, re0, rm0, bz0, rdy1, rv1, re1, rm1, bz1;
  logic [3:0]  ra0, ra1, lk0;
  logic [2:0]  lk1;
  logic [15:0] at0;
  logic [11:0] at1;

  assign req_ready[0] = rdy0;  assign req_ready[1] = rdy1;
  assign rsp_valid[0] = rv0;   assign rsp_valid[1] = rv1;
  assign rsp_err[0]   = re0;   assign rsp_err[1]   = re1;
  assign rsp_masked[0]= rm0;   assign rsp_masked[1]= rm1;
  assign busy[0]      = bz0;   assign busy[1]      = bz1;
  assign rsp_attr[0]  = ra0;   assign rsp_attr[1]  = ra1;
  assign attr_w[0]    = at0;   assign attr_w[1]    = {4'h0, at1};
  assign lock_w[0]    = lk0;   assign lock_w[1]    = {1'b0, lk1};

  pad_attr_sequencer #(
    .NumPads(4), .SettleCycles(3),
    .PadTypes({2'd1, 2'd2, 2'd0, 2'd1}), .ResetAttr(4'hF)
  ) u_dut_settle (
    .clk_i(clk), .rst_ni(rst_n[0]),
    .req_valid_i(req_valid[0]), .req_ready_o(rdy0), .req_pad_i(req_pad[0]),
    .req_attr_i(req_attr[0]), .req_lock_i(req_lock[0]),
    .rsp_valid_o(rv0), .rsp_attr_o(ra0), .rsp_err_o(re0), .rsp_masked_o(rm0),
    .attr_o(at0), .lock_o(lk0), .busy_o(bz0)
  );

  pad_attr_sequencer #(
    .NumPads(3), .SettleCycles(0),
    .PadTypes({2'd3, 2'd0, 2'd1}), .ResetAttr(4'hA)
  ) u_dut_b2b (
    .clk_i(clk), .rst_ni(rst_n[1]),
    .req_valid_i(req_valid[1]), .req_ready_o(rdy1), .req_pad_i(req_pad[1]),
    .req_attr_i(req_attr[1]), .req_lock_i(req_lock[1]),
    .rsp_valid_o(rv1), .rsp_attr_o(ra1), .rsp_err_o(re1), .rsp_masked_o(rm1),
    .attr_o(at1), .lock_o(lk1), .busy_o(bz1)
  );

  // Reference model state
  int         npads  [ND] = '{4, 3};
  int         settle [ND] = '{3, 0};
  int         ptype  [ND][4] = '{'{1, 0, 2, 1}, '{1, 0, 3, 0}};
  logic [3:0] rst_attr [ND] = '{4'hF, 4'hA};
  logic [3:0] m_attr [ND][4];
  logic       m_lock [ND][4];
  int         left   [ND];
  exp_t       sbq    [ND][$];
  bit         mon_en = 1'b0;

  int errors = 0;
  int checks = 0;

  function automatic logic [3:0] cap(int t);
    case (t)
      0:       return 4'b0111;
      1:       return 4'b1111;
      default: return 4'b0000;
    endcase
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] snap_attr(int d);
    logic [15:0] v;
    for (int p = 0; p < 4; p++) v[p*4 +: 4] = m_attr[d][p];
    return v;
  endfunction

  function automatic logic [3:0] snap_lock(int d);
    logic [3:0] v;
    for (int p = 0; p < 4; p++) v[p] = m_lock[d][p];
    return v;
  endfunction

  task automatic model_reset(input int d);
    for (int p = 0; p < 4; p++) begin
      m_attr[d][p] = (p < npads[d]) ? (rst_attr[d] & cap(ptype[d][p])) : 4'h0;
      m_lock[d][p] = 1'b0;
    end
    left[d] = 0;
    sbq[d].delete();
  endtask

  task automatic check_reset_outputs(input int d);
    chk($sformatf("rst_attr%0d", d), attr_w[d], snap_attr(d));
    chk($sformatf("rst_lock%0d", d), lock_w[d], 4'h0);
    chk($sformatf("rst_ready%0d", d), req_ready[d], 1'b1);
    chk($sformatf("rst_busy%0d", d), busy[d], 1'b0);
    chk($sformatf("rst_rspv%0d", d), rsp_valid[d], 1'b0);
  endtask

  // Issue one request; keep=1 leaves valid high so the next send can chain.
  task automatic send(input int d, input int pad, input logic [3:0] a, input logic lk, input bit keep);
    exp_t e;
    int   n;
    @(negedge clk);
    req_valid[d] = 1'b1;
    req_pad[d]   = 2'(pad);
    req_attr[d]  = a;
    req_lock[d]  = lk;
    n = 0;
    while (req_ready[d] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      chk($sformatf("ready_timeout%0d", d), req_ready[d], 1'b1);
      req_valid[d] = 1'b0;
      return;
    end
    e.err = (pad >= npads[d]) || m_lock[d][pad];
    if (e.err) begin
      e.attr   = 4'h0;
      e.masked = 1'b0;
    end else begin
      e.attr   = a & cap(ptype[d][pad]);
      e.masked = |(a & ~cap(ptype[d][pad]));
      m_attr[d][pad] = e.attr;
      if (lk) m_lock[d][pad] = 1'b1;
    end
    e.av = snap_attr(d);
    e.lv = snap_lock(d);
    sbq[d].push_back(e);
    @(posedge clk);
    #1;
    if (!keep) req_valid[d] = 1'b0;
  endtask

  task automatic monitor(input int d);
    exp_t e;
    if (rsp_valid[d] === 1'b1) begin
      if (sbq[d].size() == 0) begin
        chk($sformatf("spurious_rsp%0d", d), rsp_valid[d], 1'b0);
      end else begin
        e = sbq[d].pop_front();
        chk($sformatf("rsp_err%0d", d), rsp_err[d], e.err);
        chk($sformatf("rsp_masked%0d", d), rsp_masked[d], e.masked);
        chk($sformatf("rsp_attr%0d", d), rsp_attr[d], e.attr);
        chk($sformatf("attr_o%0d", d), attr_w[d], e.av);
        chk($sformatf("lock_o%0d", d), lock_w[d], e.lv);
        if (!e.err) left[d] = settle[d];
      end
    end
    chk($sformatf("ready%0d", d), req_ready[d], left[d] == 0);
    chk($sformatf("busy%0d", d), busy[d], left[d] != 0);
    if (left[d] > 0) left[d]--;
  endtask

  always @(negedge clk) begin
    if (mon_en) begin
      for (int d = 0; d < ND; d++) monitor(d);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int d = 0; d < ND; d++) begin
      rst_n[d]     = 1'b0;
      req_valid[d] = 1'b0;
      req_pad[d]   = 2'd0;
      req_attr[d]  = 4'h0;
      req_lock[d]  = 1'b0;
      model_reset(d);
    end
    repeat (3) @(negedge clk);
    for (int d = 0; d < ND; d++) check_reset_outputs(d);
    for (int d = 0; d < ND; d++) rst_n[d] = 1'b1;
    mon_en = 1'b1;

    // Masked write, then lock and a write to the locked pad
    send(0, 1, 4'hB, 1'b0, 1'b0);
    send(0, 0, 4'h5, 1'b1, 1'b0);
    send(0, 0, 4'hA, 1'b0, 1'b0);

    // Asynchronous reset during the second settle cycle
    send(0, 3, 4'h9, 1'b1, 1'b0);
    @(posedge clk);
    #2;
    chk("busy_before_rst", busy[0], 1'b1);
    rst_n[0] = 1'b0;
    #1;
    model_reset(0);
    check_reset_outputs(0);
    @(negedge clk);
    rst_n[0] = 1'b1;
    send(0, 0, 4'hC, 1'b0, 1'b0);

    // Random traffic, valid sometimes held through settle
    for (int k = 0; k < 40; k++) begin
      send(0, $urandom_range(0, 3), 4'($urandom), $urandom_range(0, 7) == 0,
           (k != 39) && ($urandom_range(0, 1) == 1));
    end
    req_valid[0] = 1'b0;

    // Out-of-range pad index, then back-to-back writes
    send(1, 3, 4'h6, 1'b0, 1'b0);
    for (int p = 0; p < 4; p++) send(1, p, 4'hF, 1'b0, p < 3);
    for (int k = 0; k < 30; k++) begin
      send(1, $urandom_range(0, 3), 4'($urandom), $urandom_range(0, 7) == 0,
           (k != 29) && ($urandom_range(0, 1) == 1));
    end
    req_valid[1] = 1'b0;

    repeat (6) @(negedge clk);
    for (int d = 0; d < ND; d++) chk($sformatf("sb_drain%0d", d), sbq[d].size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
